// File: rtl/alu_arbiter_if.sv
// Request, response and shared-ALU signals between requesters, the arbiter and the ALU.
// The master modport is the requester/ALU side; the slave modport is the arbiter.
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
    input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
    output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU, one transaction in flight.
// Define ALU_ARBITER_RR_EN for round-robin grant; otherwise requester 0 has fixed priority.
//
// state | meaning
// IDLE  | waiting for a request, req_ready offered to the granted requester
// EXEC  | operands on the ALU, counter runs down for multi-cycle MUL
// RESP  | response held until consumed
module alu_arbiter #(
  parameter int MUL_LAT = 3
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        id_q;
  logic        gnt;
  logic        take;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [3:0]  sel_op;

`ifdef ALU_ARBITER_RR_EN
  logic last_gnt;

  always_comb begin
    gnt = ~bus.req_valid[0];
    if (&bus.req_valid) gnt = ~last_gnt;
  end
`else
  assign gnt = ~bus.req_valid[0];
`endif

  // reset gates the handshake so nothing is offered while rst_n is low
  always_comb begin
    bus.req_ready = 2'b00;
    if (rst_n && (state == IDLE))
      bus.req_ready = {gnt & bus.req_valid[1], ~gnt & bus.req_valid[0]};
  end

  assign take   = |bus.req_ready;
  assign sel_a  = gnt ? bus.req_a[63:32] : bus.req_a[31:0];
  assign sel_b  = gnt ? bus.req_b[63:32] : bus.req_b[31:0];
  assign sel_op = gnt ? bus.req_op[7:4]  : bus.req_op[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      id_q           <= 1'b0;
      bus.alu_a      <= 32'd0;
      bus.alu_b      <= 32'd0;
      bus.alu_ctrl   <= 4'd0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= 32'd0;
      bus.rsp_zero   <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
      last_gnt       <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            bus.alu_a    <= sel_a;
            bus.alu_b    <= sel_b;
            bus.alu_ctrl <= sel_op;
            id_q         <= gnt;
            cnt          <= (sel_op == OP_MUL) ? MUL_CNT : 4'd0;
            state        <= EXEC;
`ifdef ALU_ARBITER_RR_EN
            last_gnt     <= gnt;
`endif
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_zero   <= bus.alu_zero;
            bus.rsp_id     <= id_q;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MUL_LAT, default 3, cycles the shared ALU needs for a MUL (alu_ctrl 4'b1000), legal range 1..15.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept, bit i = requester i.
REQ-006 req_a  input  64  operand A, requester i at [32i+31:32i].
REQ-007 req_b  input  64  operand B, same packing.
REQ-008 req_op  input  8  ALU opcode, requester i at [4i+3:4i].
REQ-009 alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-010 alu_ctrl  output  4  opcode driven to the shared ALU.
REQ-011 alu_result  input  32  ALU result.
REQ-012 alu_zero  input  1  ALU zero flag.
REQ-013 rsp_valid  output  1  response valid.
REQ-014 rsp_ready  input  1  response accept from consumer.
REQ-015 rsp_id  output  1  index of the requester owning the response.
REQ-016 rsp_result  output  32  captured result; rsp_zero output 1 captured zero flag.

Function
REQ-017 FSM states: IDLE, EXEC, RESP; exactly one transaction in flight.
REQ-018 In IDLE, req_ready asserts combinationally for the granted requester only, when its req_valid=1; both bits 0 in EXEC/RESP.
REQ-019 Transfer occurs on req_valid[i] & req_ready[i]; operands, opcode and id are registered; state goes EXEC.
REQ-020 alu_a/alu_b/alu_ctrl come from the operand registers and hold stable from the cycle after transfer until the next transfer.
REQ-021 Non-MUL: EXEC lasts 1 cycle; alu_result/alu_zero captured at end of EXEC.
REQ-022 MUL: EXEC lasts MUL_LAT cycles via a down-counter; capture at end of the last EXEC cycle.
REQ-023 Latency: transfer in cycle T gives rsp_valid in T+2 (non-MUL) or T+1+MUL_LAT (MUL).
REQ-024 RESP: rsp_valid=1; rsp_id/rsp_result/rsp_zero held stable until rsp_valid & rsp_ready, then IDLE next cycle.
REQ-025 A new request is not accepted in the cycle the response is consumed; earliest next transfer is the following IDLE cycle.
REQ-026 Opcodes not defined for the ALU are passed through unchanged; the captured result (0) and zero flag (1) are returned normally.
REQ-027 req_valid deasserting before transfer is legal; no grant state changes without a transfer.
REQ-028 Arbitration selects among req_valid bits only; with no valid request FSM stays in IDLE.

Reset
REQ-029 rst_n low immediately forces IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, alu_a=0, alu_b=0, alu_ctrl=0, counter=0.
REQ-030 Reset during EXEC or RESP discards the transaction with no response produced.
REQ-031 Last-grant register resets to 1, so requester 0 wins the first contended arbitration.

Configuration
REQ-032 Macro ALU_ARBITER_RR_EN defined: round-robin; when both valid, grant goes to the requester not granted at the last transfer; last-grant updates on every transfer.
REQ-033 Macro ALU_ARBITER_RR_EN undefined: fixed priority, requester 0 always wins contention; last-grant register omitted.

Verification
REQ-034 Single ADD: req0 a=5 b=7 op=0010 at T, rsp_ready=1 -> rsp_valid at T+2, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-035 MUL with MUL_LAT=3: req1 a=6 b=7 op=1000 at T -> rsp_valid at T+4, rsp_id=1, rsp_result=42; alu_ctrl stable 1000 over T+1..T+3.
REQ-036 Contention, RR_EN defined: both valid continuously, 4 SUBs each -> grants alternate 0,1,0,1,0,1,0,1; RR_EN undefined -> four 0 grants before any 1.
REQ-037 Backpressure: SLT a=3 b=9, rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_result=1 stable, req_ready=00 throughout; consumed on first rsp_ready=1.
REQ-038 Undefined op 0011 with a=b=0xFFFFFFFF -> rsp_result=0, rsp_zero=1.
REQ-039 rst_n pulsed low in second EXEC cycle of a MUL -> all outputs zero asynchronously, no rsp_valid afterward, next request served normally.
